mdu_32: RTL and testbench
=========================

# mdu_32

Sequential 32-bit multiply/divide unit for the MIPS execute stage. It sits beside `alu_32`, takes the same rs/rt operands, and executes MULT, MULTU, DIV and DIVU over 34 cycles into architectural HI/LO registers. HI/LO feed the MFHI/MFLO path of the result mux downstream of the ALU. The `busy` output lets the control unit stall the PC while an operation is in flight.

## Interface
Parameters:
- `ITER`, 32: iteration count. Must equal the operand width and is not intended to be overridden.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs operand (multiplicand or dividend).
- `b`  in  32  rt operand (multiplier or divisor).
- `hi_we`  in  1  MTHI write strobe.
- `lo_we`  in  1  MTLO write strobe.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  high while state is not IDLE.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `div_by_zero`  out  1  valid while `done` is high; set for DIV/DIVU with b == 0.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

Clocking and reset (already decided): one clock; reset is asynchronous and active-low.

## Operation
States and transitions:
- IDLE → CALC on `start`.
- CALC → FIX after 32 iterations.
- FIX → IDLE unconditionally.

Launch (IDLE with `start` = 1):
- Latch `op`.
- For signed ops, latch the magnitudes of `a` and `b` and the result sign flags. Unsigned ops latch raw values.
- Clear the 6-bit iteration counter.

CALC, one step per cycle:
- Multiply: radix-2 shift-add into a 64-bit accumulator.
- Divide: restoring shift-subtract producing a 32-bit quotient and 32-bit remainder.

FIX:
- Apply sign correction and write HI/LO.
- Multiply: {hi, lo} = 64-bit product. Signed ops negate the full 64 bits when the operand signs differ.
- Divide: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
- DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. No trap is raised.
- Divide by zero (either signedness): hi = original `a`, lo = 0xFFFFFFFF, `div_by_zero` = 1. The full 34-cycle latency is still taken.

Boundary conditions:
- `start` while `busy`: ignored, with no queuing.
- `hi_we`/`lo_we` while `busy`: ignored.
- `hi_we`/`lo_we` in IDLE without `start`: writes `wdata` to the selected register at the edge. Both strobes together write both registers.
- `start` together with `hi_we`/`lo_we` in IDLE: `start` wins and the writes are dropped.
- Operands are captured at launch only. `a`, `b` and `op` may change during CALC without effect.

## Timing
- Start accepted at edge E0. `busy` = 1 from after E0 through E33.
- CALC occupies edges E1–E32. FIX occupies E33.
- E33 updates HI/LO and asserts `done` (plus `div_by_zero` if applicable) for exactly one cycle; the state returns to IDLE.
- A new `start` is accepted at E34 or later, so the throughput is one operation per 34 cycles.
- HI/LO are stable, showing the previous values, from E0 through E33.
- MTHI/MTLO take effect at the edge where they are sampled; `hi`/`lo` show the new value in the next cycle.
- Reset values: state IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0, counter 0.
- `rst_n` low mid-operation aborts immediately. No `done` is produced and HI/LO go to 0.

## Structure
- Shared package `mdu_pkg` holds:
  - op encodings `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`;
  - the state typedef `mdu_state_t` {IDLE, CALC, FIX};
  - the constant `MDU_ITER` = 32.
- Natural sub-module: `mdu_step`, the combinational single-iteration datapath.
  - Inputs: 64-bit working register, operand, mode.
  - Outputs: next working register.
  - Covers both the shift-add and shift-subtract steps.
- FSM, counter, sign handling and HI/LO stay in `mdu_32`.

## Test plan
- MULT a = 0xFFFFFFFD (−3), b = 7 → at E33 `done`=1, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; `busy` high E0–E33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- DIV a = −7, b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIVU 7 / 2 → lo = 3, hi = 1.
  - DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU 5 / 0 → hi = 5, lo = 0xFFFFFFFF, `div_by_zero` = 1 in the `done` cycle only.
  - DIV −5 / 0 → hi = 0xFFFFFFFB, lo = 0xFFFFFFFF.
- MTHI 0x12345678 in IDLE → hi updated next cycle. Then:
  - `start` at cycle 10 of an active op is ignored;
  - `hi_we` during `busy` is ignored;
  - `start` and `lo_we` together → only the op runs.
- `rst_n` pulsed low during CALC cycle 10 → `busy`, `done` and `div_by_zero` = 0 immediately, hi = lo = 0, and no `done` afterward.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// iteration count and a small op-decoding helper.
package mdu_pkg;

   localparam int MDU_ITER = 32;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } mdu_state_t;

   // True for the signed variants (MULT, DIV).
   function automatic logic mdu_is_signed(input logic [1:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

   // True for the divide variants (DIV, DIVU).
   function automatic logic mdu_is_div(input logic [1:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Multiply: working register is {accumulator, multiplier}; the operand is the
//   multiplicand. Each step conditionally adds and shifts right by one.
// Divide: working register is {remainder, dividend/quotient}; the operand is
//   the divisor. Each step shifts left by one and does a restoring subtract,
//   shifting the quotient bit in at the bottom.
module mdu_step (
   input  logic [63:0] i_work,
   input  logic [31:0] i_operand,
   input  logic        i_div,
   output logic [63:0] o_work
);

   logic [31:0] w_addend;
   logic [32:0] w_sum;
   logic [32:0] w_shift_hi;
   logic        w_ge;
   logic [31:0] w_diff;

   // Shift-add: the carry out of the add becomes the new top bit after the shift.
   assign w_addend = i_work[0] ? i_operand : 32'd0;
   assign w_sum    = {1'b0, i_work[63:32]} + {1'b0, w_addend};

   // Shift-subtract: the partial remainder is below 2^32 after a successful
   // subtract, so 32 bits of difference are enough.
   assign w_shift_hi = i_work[63:31];
   assign w_ge       = (w_shift_hi >= {1'b0, i_operand});
   assign w_diff     = w_shift_hi[31:0] - i_operand;

   // Select the step for the active mode.
   always_comb begin
      o_work = {w_sum, i_work[31:1]};
      if (i_div) begin
         if (w_ge)
            o_work = {w_diff, i_work[30:0], 1'b1};
         else
            o_work = {i_work[62:0], 1'b0};
      end
   end

endmodule

// File: rtl/mdu_32.sv
// Sequential 32-bit multiply/divide unit with architectural HI/LO.
// Operands are reduced to magnitudes at launch, iterated 32 times through
// mdu_step, and sign-corrected into HI/LO in the final FIX cycle.
module mdu_32
   import mdu_pkg::*;
#(
   parameter int ITER = MDU_ITER
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

   mdu_state_t  r_state;
   logic [5:0]  r_cnt;
   logic [63:0] r_work;
   logic [31:0] r_operand;
   logic [31:0] r_a_orig;
   logic        r_is_div;
   logic        r_neg_res;
   logic        r_neg_rem;
   logic        r_busy;
   logic        r_done;
   logic        r_dbz;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_signed;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [63:0] w_step;
   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   // Magnitudes for signed ops; 0x80000000 maps to 2^31 as an unsigned value.
   assign w_signed = mdu_is_signed(op);
   assign w_mag_a  = (w_signed && a[31]) ? (~a + 32'd1) : a;
   assign w_mag_b  = (w_signed && b[31]) ? (~b + 32'd1) : b;

   mdu_step u_step (
      .i_work    (r_work),
      .i_operand (r_operand),
      .i_div     (r_is_div),
      .o_work    (w_step)
   );

   // Sign correction applied in FIX.
   assign w_prod = r_neg_res ? (~r_work + 64'd1) : r_work;
   assign w_quo  = r_neg_res ? (~r_work[31:0] + 32'd1) : r_work[31:0];
   assign w_rem  = r_neg_rem ? (~r_work[63:32] + 32'd1) : r_work[63:32];

   // Control FSM, iteration datapath and HI/LO registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= 6'd0;
         r_work    <= 64'd0;
         r_operand <= 32'd0;
         r_a_orig  <= 32'd0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_dbz     <= 1'b0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
      end else begin
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  // Launch wins over any concurrent MTHI/MTLO.
                  r_state   <= CALC;
                  r_busy    <= 1'b1;
                  r_cnt     <= 6'd0;
                  r_a_orig  <= a;
                  r_is_div  <= mdu_is_div(op);
                  r_neg_res <= w_signed && (a[31] ^ b[31]);
                  r_neg_rem <= w_signed && a[31];
                  if (mdu_is_div(op)) begin
                     r_work    <= {32'd0, w_mag_a};
                     r_operand <= w_mag_b;
                  end else begin
                     r_work    <= {32'd0, w_mag_b};
                     r_operand <= w_mag_a;
                  end
               end else begin
                  if (hi_we) r_hi <= wdata;
                  if (lo_we) r_lo <= wdata;
               end
            end
            CALC: begin
               r_work <= w_step;
               r_cnt  <= r_cnt + 6'd1;
               if (r_cnt == LAST_CNT) r_state <= FIX;
            end
            FIX: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               if (r_is_div) begin
                  if (r_operand == 32'd0) begin
                     r_hi  <= r_a_orig;
                     r_lo  <= 32'hFFFF_FFFF;
                     r_dbz <= 1'b1;
                  end else begin
                     r_hi <= w_rem;
                     r_lo <= w_quo;
                  end
               end else begin
                  r_hi <= w_prod[63:32];
                  r_lo <= w_prod[31:0];
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign div_by_zero = r_dbz;
   assign hi          = r_hi;
   assign lo          = r_lo;

endmodule

// File: tb/tb_mdu_32.sv
// Scoreboard bench for mdu_32: each launched op pushes its hand-computed
// HI/LO/div_by_zero result; a monitor pops and compares on every done pulse.
module tb_mdu_32;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   mdu_32 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: compares every done pulse against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
               exp_t e;
               e = sb.pop_front();
               check32("result_hi", hi, e.hi);
               check32("result_lo", lo, e.lo);
               check32("result_dbz", {31'd0, div_by_zero}, {31'd0, e.dbz});
               check32("busy_at_done", {31'd0, busy}, 32'd0);
               $display("op done: hi=%h lo=%h dbz=%0d", hi, lo, div_by_zero);
            end
         end else if (div_by_zero) begin
            n_err++;
            $display("FAIL dbz_without_done: got div_by_zero=1 expected 0");
         end
      end
   end

   // Launch one op, disturb it mid-CALC, and check latency and HI/LO hold.
   task automatic run_op(input logic [1:0] f_op, input logic [31:0] fa, input logic [31:0] fb,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                         input logic with_lo_we);
      int   lat;
      logic hold_bad;
      exp_t e;
      e.hi = ehi; e.lo = elo; e.dbz = edbz;
      sb.push_back(e);
      $display("launch op=%0d a=%h b=%h lo_we=%0d", f_op, fa, fb, with_lo_we);
      @(negedge clk);
      start = 1'b1; op = f_op; a = fa; b = fb;
      lo_we = with_lo_we; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0; lo_we = 1'b0;
      check32("busy_after_E0", {31'd0, busy}, 32'd1);
      lat = 1;
      hold_bad = 1'b0;
      while (!done && lat < 60) begin
         if (hi !== exp_hi || lo !== exp_lo) hold_bad = 1'b1;
         if (!busy) hold_bad = 1'b1;
         if (lat == 10) begin
            start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_AAAA;
            op = ~f_op; a = ~fa; b = fb + 32'd3;
         end else if (lat == 11) begin
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      if (!done) $display("FAIL timeout: got no done after %0d cycles expected 34", lat);
      check32("latency", 32'(lat), 32'd34);
      check32("hold_hi_lo_busy", {31'd0, hold_bad}, 32'd0);
      exp_hi = ehi;
      exp_lo = elo;
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check32("reset_hi", hi, 32'd0);
      check32("reset_lo", lo, 32'd0);
      check32("reset_ctrl", {29'd0, busy, done, div_by_zero}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // MTHI, MTLO and both together in IDLE.
      hi_we = 1'b1; wdata = 32'h1234_5678;
      @(negedge clk); hi_we = 1'b0;
      check32("mthi_hi", hi, 32'h1234_5678);
      check32("mthi_lo", lo, 32'd0);
      lo_we = 1'b1; wdata = 32'hCAFE_BABE;
      @(negedge clk); lo_we = 1'b0;
      check32("mtlo_lo", lo, 32'hCAFE_BABE);
      check32("mtlo_hi", hi, 32'h1234_5678);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
      check32("mtboth_hi", hi, 32'h0BAD_F00D);
      check32("mtboth_lo", lo, 32'h0BAD_F00D);
      exp_hi = 32'h0BAD_F00D;
      exp_lo = 32'h0BAD_F00D;

      run_op(2'b00, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
      run_op(2'b00, 32'h0001_0000, 32'hFFFF_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
      run_op(2'b11, 32'd7,         32'd2,          32'd1,         32'd3,         1'b0, 1'b0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 1'b0, 1'b0);
      run_op(2'b10, 32'd100,       32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFF2, 1'b0, 1'b0);
      run_op(2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd14,        1'b0, 1'b0);
      run_op(2'b11, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op(2'b10, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op(2'b01, 32'd3,         32'd5,          32'd0,         32'd15,        1'b0, 1'b0);
      // start together with lo_we: the op runs, the write is dropped.
      run_op(2'b01, 32'd2,         32'd3,          32'd0,         32'd6,         1'b0, 1'b1);

      // Asynchronous reset during CALC aborts with no done.
      $display("launch DIVU then reset mid-CALC");
      @(negedge clk);
      start = 1'b1; op = 2'b11; a = 32'hFFFF_FFFF; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check32("abort_ctrl", {29'd0, busy, done, div_by_zero}, 32'd0);
      check32("abort_hi", hi, 32'd0);
      check32("abort_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check32("abort_busy_after", {31'd0, busy}, 32'd0);
      check32("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
